// File: rtl/cl_axi_mem_pkg.sv
// cl_axi_mem_pkg: response codes, FSM state types and beat geometry shared by
// the AXI block-RAM responder and its read output queue.
package cl_axi_mem_pkg;
    localparam int BEAT_BYTES = 64;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_BURST} rd_state_t;
endpackage

// File: rtl/cl_axi_mem_rdq.sv
// cl_axi_mem_rdq: 2-entry R-channel output FIFO fed by a 1-cycle-latency RAM,
// with credit so issued-but-unlanded reads never overflow the queue.
module cl_axi_mem_rdq
    import cl_axi_mem_pkg::*;
#(
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              pipe_rst_n,
    input  logic              issue_i,
    input  logic              last_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] ram_data_i,
    input  logic              rready_i,
    output logic              credit_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              rvalid_o
);
    logic              inf_q, inf_last_q, inf_err_q;
    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q, err_q;
    logic              wr_ptr_q, rd_ptr_q, pop;
    logic [1:0]        cnt_q;

    assign rvalid_o = cnt_q != 2'd0;
    assign pop      = rvalid_o && rready_i;
    // A beat leaving this cycle frees its slot, which keeps streaming at one beat per clock.
    assign credit_o = ({1'b0, cnt_q} + {2'b0, inf_q} - {2'b0, pop}) < 3'd2;
    assign rdata_o  = data_q[rd_ptr_q];
    assign rlast_o  = last_q[rd_ptr_q];
    assign rresp_o  = err_q[rd_ptr_q] ? SLVERR : OKAY;

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            inf_q      <= 1'b0;
            inf_last_q <= 1'b0;
            inf_err_q  <= 1'b0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            last_q     <= '0;
            err_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inf_q      <= issue_i;
            inf_last_q <= last_i;
            inf_err_q  <= err_i;
            if (inf_q) begin
                data_q[wr_ptr_q] <= inf_err_q ? '0 : ram_data_i;
                last_q[wr_ptr_q] <= inf_last_q;
                err_q[wr_ptr_q]  <= inf_err_q;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, inf_q} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/cl_axi_mem_responder.sv
// cl_axi_mem_responder: AXI4 INCR-burst slave over byte-writable block RAM, one burst per direction.
// Define CL_AXI_MEM_RANGE_CHK_EN to flag bursts that run outside the RAM window.
module cl_axi_mem_responder
    import cl_axi_mem_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 512,
    parameter int ID_W       = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                pipe_rst_n,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(BEAT_BYTES);
    localparam int IDX_HI = DEPTH_LOG2 + OFF_W - 1;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     ram_rdata_q;
    logic                  rst_done_q, aw_flag, ar_flag, unused_addr;
    wr_state_t             w_state_q, w_state_d;
    logic [ID_W-1:0]       w_id_q, r_id_q;
    logic [DEPTH_LOG2-1:0] w_idx_q, r_idx_q;
    logic [7:0]            w_len_q, r_len_q;
    logic [8:0]            w_cnt_q, r_iss_q;
    logic                  w_err_q, aw_hs, w_hs, b_hs, w_en;
    rd_state_t             r_state_q, r_state_d;
    logic                  r_err_q, ar_hs, r_issue, r_credit, r_done;

    assign unused_addr = ^{s_awaddr, s_araddr};

`ifdef CL_AXI_MEM_RANGE_CHK_EN
    // Widened by one bit so start+len cannot overflow; any bit at or above DEPTH_LOG2 is out of window.
    assign aw_flag = ({1'b0, s_awaddr[ADDR_W-1:OFF_W]} + (ADDR_W-OFF_W+1)'(s_awlen)) >= (ADDR_W-OFF_W+1)'(DEPTH);
    assign ar_flag = ({1'b0, s_araddr[ADDR_W-1:OFF_W]} + (ADDR_W-OFF_W+1)'(s_arlen)) >= (ADDR_W-OFF_W+1)'(DEPTH);
`else
    assign aw_flag = 1'b0;
    assign ar_flag = 1'b0;
`endif

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign b_hs  = s_bvalid && s_bready;
    assign w_en  = w_hs && !w_err_q && w_cnt_q <= {1'b0, w_len_q};

    always_comb begin
        s_awready = rst_done_q && w_state_q == W_IDLE;
        s_wready  = w_state_q == W_DATA;
        s_bvalid  = w_state_q == W_RESP;
        s_bid     = w_id_q;
        s_bresp   = w_err_q ? SLVERR : OKAY;
        w_state_d = aw_hs ? W_DATA : (w_hs && s_wlast) ? W_RESP : b_hs ? W_IDLE : w_state_q;
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            w_id_q     <= '0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            w_state_q  <= w_state_d;
            if (aw_hs) begin
                w_id_q  <= s_awid;
                w_idx_q <= s_awaddr[IDX_HI:OFF_W];
                w_len_q <= s_awlen;
                w_cnt_q <= '0;
                w_err_q <= aw_flag;
            end else if (w_hs) begin
                w_idx_q <= w_idx_q + DEPTH_LOG2'(1);
                w_cnt_q <= w_cnt_q + 9'd1;
                if (w_cnt_q > {1'b0, w_len_q}) w_err_q <= 1'b1;
            end
        end
    end

    assign ar_hs   = s_arvalid && s_arready;
    assign r_done  = s_rvalid && s_rready && s_rlast;
    assign r_issue = r_state_q == R_BURST && r_iss_q <= {1'b0, r_len_q} && r_credit;

    always_comb begin
        s_arready = rst_done_q && r_state_q == R_IDLE;
        s_rid     = r_id_q;
        r_state_d = ar_hs ? R_BURST : r_done ? R_IDLE : r_state_q;
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_iss_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                r_id_q  <= s_arid;
                r_idx_q <= s_araddr[IDX_HI:OFF_W];
                r_len_q <= s_arlen;
                r_iss_q <= '0;
                r_err_q <= ar_flag;
            end else if (r_issue) begin
                r_idx_q <= r_idx_q + DEPTH_LOG2'(1);
                r_iss_q <= r_iss_q + 9'd1;
            end
        end
    end

    // Read-first: a same-cycle write to the read index lands after the old word is captured.
    always_ff @(posedge clk) begin
        if (r_issue) ram_rdata_q <= mem[r_idx_q];
        for (int b = 0; b < STRB_W; b++)
            if (w_en && s_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end

    cl_axi_mem_rdq #(.DATA_W(DATA_W)) u_rdq (
        .clk        (clk),
        .pipe_rst_n (pipe_rst_n),
        .issue_i    (r_issue),
        .last_i     (r_iss_q[7:0] == r_len_q),
        .err_i      (r_err_q),
        .ram_data_i (ram_rdata_q),
        .rready_i   (s_rready),
        .credit_o   (r_credit),
        .rdata_o    (s_rdata),
        .rresp_o    (s_rresp),
        .rlast_o    (s_rlast),
        .rvalid_o   (s_rvalid)
    );
endmodule

// File: tb/tb_cl_axi_mem_responder.sv
// tb_cl_axi_mem_responder: directed and randomized bursts checked against a
// beat-array memory model of the responder.
module tb_cl_axi_mem_responder;
    localparam int DEPTH = 1024;
    localparam int TMO   = 60;

    logic         clk = 1'b0, pipe_rst_n = 1'b0;
    logic [15:0]  s_awid, s_bid, s_arid, s_rid;
    logic [63:0]  s_awaddr, s_araddr, s_wstrb;
    logic [7:0]   s_awlen, s_arlen;
    logic         s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic         s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [511:0] s_wdata, s_rdata;
    logic [1:0]   s_bresp, s_rresp;

    int           checks = 0, errors = 0;
    logic [511:0] ref_mem [DEPTH];
    logic [511:0] wd [256];
    logic [63:0]  ws [256];
    logic [1:0]   dummy;

    cl_axi_mem_responder dut (
        .clk(clk), .pipe_rst_n(pipe_rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic bit m_flag(input logic [63:0] addr, input int len);
`ifdef CL_AXI_MEM_RANGE_CHK_EN
        return ((addr >> 6) + 64'(len)) >= 64'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [63:0] addr, input int k);
        return int'(((addr >> 6) + 64'(k)) % 64'(DEPTH));
    endfunction

    // Apply n beats of wd/ws to the model; returns the expected bresp.
    function automatic logic [1:0] m_write(input logic [63:0] addr, input int len, input int n);
        bit f = m_flag(addr, len);
        for (int k = 0; k < n; k++)
            if (!f && k <= len)
                for (int b = 0; b < 64; b++)
                    if (ws[k][b]) ref_mem[m_idx(addr, k)][b*8 +: 8] = wd[k][b*8 +: 8];
        return (f || n > len + 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic send_aw(input logic [15:0] id, input logic [63:0] addr, input int len);
        int t;
        t = 0;
        s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awvalid = 1'b1;
        while (!s_awready && t < TMO) begin @(negedge clk); t++; end
        chk("aw_accept", 512'(t < TMO), 512'(1));
        @(negedge clk);
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input int n, input bit with_last);
        int t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            s_wdata = wd[k]; s_wstrb = ws[k]; s_wlast = with_last && k == n - 1; s_wvalid = 1'b1;
            while (!s_wready && t < TMO) begin @(negedge clk); t++; end
            chk("w_accept", 512'(t < TMO), 512'(1));
            @(negedge clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
    endtask

    task automatic recv_b(input logic [15:0] id, input logic [1:0] resp, input string tag);
        int t;
        t = 0;
        s_bready = 1'b1;
        while (!s_bvalid && t < TMO) begin @(negedge clk); t++; end
        chk({tag, "_bvalid"}, 512'(s_bvalid), 512'(1));
        chk({tag, "_bid"}, 512'(s_bid), 512'(id));
        chk({tag, "_bresp"}, 512'(s_bresp), 512'(resp));
        @(negedge clk);
        s_bready = 1'b0;
        chk({tag, "_bvalid_clear"}, 512'(s_bvalid), 512'(0));
    endtask

    task automatic do_write(input logic [15:0] id, input logic [63:0] addr, input int len, input int n, input string tag);
        logic [1:0] exp;
        exp = m_write(addr, len, n);
        send_aw(id, addr, len);
        send_w(n, 1'b1);
        recv_b(id, exp, tag);
    endtask

    // mode 0: rready held high; 1: 1010 with a 5-cycle low hold; 2: random.
    task automatic recv_r(input logic [15:0] id, input logic [63:0] addr, input int len, input int mode, input string tag);
        int t, c, b;
        bit f, rr, stalled;
        logic [511:0] held;
        f = m_flag(addr, len);
        s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arvalid = 1'b1; s_rready = 1'b0;
        t = 0;
        while (!s_arready && t < TMO) begin @(negedge clk); t++; end
        chk({tag, "_ar_accept"}, 512'(t < TMO), 512'(1));
        t = 0;
        do begin @(negedge clk); s_arvalid = 1'b0; t++; end while (!s_rvalid && t < TMO);
        chk({tag, "_first_lat"}, 512'(t), 512'(3));
        b = 0; c = 0; stalled = 1'b0; held = '0;
        while (b <= len && c < 4 * (len + 1) + TMO) begin
            if (s_rvalid) begin
                if (stalled) chk({tag, "_stall_hold"}, s_rdata, held);
                rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((c >= 4 && c < 9) ? 1'b0 : (c % 2 == 0)) : 1'($urandom_range(0, 1));
                s_rready = rr;
                if (rr) begin
                    chk({tag, "_rdata"}, s_rdata, f ? 512'(0) : ref_mem[m_idx(addr, b)]);
                    chk({tag, "_rid_resp_last"}, 512'({s_rid, s_rresp, s_rlast}), 512'({id, f ? 2'b10 : 2'b00, b == len}));
                    b++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = s_rdata;
                end
            end else begin
                chk({tag, "_rvalid_drop"}, 512'(stalled), 512'(0));
                s_rready = 1'b0;
            end
            c++;
            @(negedge clk);
        end
        s_rready = 1'b0;
        chk({tag, "_beats"}, 512'(b), 512'(len + 1));
        if (mode == 0) chk({tag, "_throughput"}, 512'(c), 512'(len + 1));
        chk({tag, "_no_extra"}, 512'(s_rvalid), 512'(0));
    endtask

    initial begin
        logic [63:0] a;
        int len;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 512'({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast}), 512'(0));
        chk("rst_ids", 512'({s_bid, s_rid, s_bresp, s_rresp}), 512'(0));
        chk("rst_rdata", s_rdata, 512'(0));
        pipe_rst_n = 1'b1;
        #1 chk("rst_ready_pre_clk", 512'({s_awready, s_arready}), 512'(0));
        @(posedge clk);
        #1 chk("rst_ready_first_clk", 512'({s_awready, s_arready}), 512'(2'b11));
        @(negedge clk);

        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 256; k++) begin wd[k] = rand512(); ws[k] = '1; end
            do_write(16'(blk), 64'(blk * 256 * 64), 255, 256, "fill");
        end
        recv_r(16'hA, 64'h4000, 255, 0, "long_rd");

        for (int k = 0; k < 4; k++) begin wd[k] = 512'(8'hA0 + k); ws[k] = '1; end
        do_write(16'h5, 64'h40, 3, 4, "rt_wr");
        recv_r(16'h9, 64'h40, 3, 0, "rt_rd");
        recv_r(16'h3, 64'h40, 3, 1, "bp_rd");

        wd[0] = '1; ws[0] = '1;
        do_write(16'h1, 64'h200, 0, 1, "ps_ones");
        wd[0] = '0; ws[0] = 64'hFF;
        do_write(16'h1, 64'h200, 0, 1, "ps_low");
        recv_r(16'h2, 64'h200, 0, 0, "ps_rd");

        wd[0] = rand512(); ws[0] = '1;
        do_write(16'h7, 64'h0, 0, 1, "wrap_pre");
        wd[0] = rand512(); wd[1] = rand512(); ws[0] = '1; ws[1] = '1;
        do_write(16'h8, 64'hFFC0, 1, 2, "wrap_wr");
        recv_r(16'h8, 64'h0, 0, 0, "wrap_idx0");
        recv_r(16'h8, 64'hFFC0, 1, 2, "wrap_rd");

        for (int k = 0; k < 3; k++) begin wd[k] = rand512(); ws[k] = '1; end
        do_write(16'h4, 64'h400, 1, 3, "lm_wr");
        recv_r(16'h4, 64'h400, 2, 2, "lm_rd");

        for (int k = 0; k < 4; k++) begin wd[k] = rand512(); ws[k] = '1; end
        dummy = m_write(64'h800, 3, 2);
        send_aw(16'h6, 64'h800, 3);
        send_w(2, 1'b0);
        pipe_rst_n = 1'b0;
        #1 chk("mid_rst_bvalid", 512'({s_bvalid, s_awready}), 512'(0));
        @(negedge clk);
        chk("mid_rst_hold", 512'({s_bvalid, s_wready}), 512'(0));
        pipe_rst_n = 1'b1;
        #1 chk("mid_rst_release", 512'(s_awready), 512'(0));
        @(posedge clk);
        #1 chk("mid_rst_first_clk", 512'({s_awready, s_bvalid, s_wready}), 512'(3'b100));
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin wd[k] = rand512(); ws[k] = '1; end
        do_write(16'h6, 64'h800, 3, 4, "rst_wr2");
        recv_r(16'h6, 64'h800, 3, 2, "rst_rd");

        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(0, 7);
            a = {$urandom(), $urandom()} & 64'h0000_0000_0000_FFFF;
            if (i == 5) a[40] = 1'b1;
            for (int k = 0; k <= len; k++) begin wd[k] = rand512(); ws[k] = {$urandom(), $urandom()}; end
            do_write(16'($urandom()), a, len, len + 1, "rnd_wr");
            recv_r(16'($urandom()), a, len, 2, "rnd_rd");
        end

        for (int k = 0; k < 4; k++) begin wd[k] = rand512(); ws[k] = '1; end
        fork
            do_write(16'h11, 64'h1000, 3, 4, "cc_wr");
            recv_r(16'h22, 64'h2000, 3, 0, "cc_rd");
        join
        recv_r(16'h33, 64'h1000, 3, 0, "cc_chk");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cl_axi_mem_responder.md
Name: cl_axi_mem_responder

Overview:
AXI4 slave (responder) backed by on-chip block RAM. It accepts AR/AW/W bursts from the StreamingWrapper-side initiator and returns R/B responses. The CL substitutes it for the DDR path during bring-up and in fast regression, so the streaming engine can be exercised without the shell DDR model. Read and write channels are independent, with one outstanding burst per direction.

Parameters:
ADDR_W, 64, AXI address width
DATA_W, 512, data width (64 B beats only)
ID_W, 16, AXI ID width
DEPTH_LOG2, 10, log2 of memory depth in beats (default 1024 x 64 B = 64 KB)

Ports:
clk  in  1  clock
pipe_rst_n  in  1  asynchronous, active-low reset
s_awid  in  ID_W  write burst ID
s_awaddr  in  ADDR_W  write byte address
s_awlen  in  8  beats minus 1
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte enables
s_wlast  in  1  final write beat
s_wvalid  in  1  W valid
s_wready  out  1  W ready
s_bid  out  ID_W  response ID
s_bresp  out  2  write response
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_arid  in  ID_W  read burst ID
s_araddr  in  ADDR_W  read byte address
s_arlen  in  8  beats minus 1
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rid  out  ID_W  read ID
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_rlast  out  1  final read beat
s_rvalid  out  1  R valid
s_rready  in  1  R ready

Behaviour:
- Reset: all outputs 0; FSMs go to IDLE; memory contents are not cleared. Readies assert on the first clk after release. Reset asserted mid-burst aborts the burst and issues no response.
- Beat index = addr[DEPTH_LOG2+5:6]. Bits [5:0] are ignored. Bursts are INCR only; the size is fixed at 64 B. The index wraps modulo 2^DEPTH_LOG2.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. The AW handshake latches id, index, len and beat count 0.
  - W_DATA: wready=1. Each W handshake writes the enabled bytes and increments the index and count.
  - A beat with count > len is not written and forces bresp=SLVERR (2'b10).
  - The wlast handshake moves the FSM to W_RESP; only wlast ends the burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY unless flagged. The B handshake returns to W_IDLE.
- Read FSM, R_IDLE -> R_BURST:
  - R_IDLE: arready=1. The AR handshake latches id, index and len.
  - R_BURST: synchronous RAM read with 1-cycle latency feeds a 2-entry output FIFO. A RAM read is issued only when (FIFO occupancy + in-flight) < 2, so back-to-back beats flow at 1/cycle while rready=1.
  - The first rvalid appears 2 cycles after the AR handshake.
  - rdata, rid and rlast hold stable while rvalid && !rready.
  - rlast is asserted on beat len. rresp=OKAY. The FSM returns to R_IDLE after the rlast handshake.
- Same-cycle read and write to the same index: the read returns old data (read-first RAM).
- AR and AW are accepted concurrently; there is no ordering between the channels.

Optional Feature:
Macro CL_AXI_MEM_RANGE_CHK_EN.
- Defined: a burst whose start or end beat lies at or beyond 2^DEPTH_LOG2, or whose addr[ADDR_W-1:DEPTH_LOG2+6] is nonzero, is flagged.
  - Flagged write: no data is written and bresp=SLVERR.
  - Flagged read: the burst returns len+1 beats of zero data with rresp=SLVERR.
- Undefined: no check; addresses wrap silently.

Decomposition:
- Package cl_axi_mem_pkg holds:
  - the resp constants OKAY=2'b00 and SLVERR=2'b10;
  - the wr_state_t and rd_state_t enums;
  - the BEAT_BYTES=64 localparam.
- Sub-module cl_axi_mem_rdq is the 2-entry read output FIFO with occupancy/credit logic. The RAM itself is inferred in the top module, with byte-write enables.

Test Plan:
- Write/read round trip: AW addr 0x40 len 3, beats 0xA0..0xA3, full strobes -> one B with bid=0x5, bresp=0. Then AR 0x40 len 3 -> 4 beats 0xA0..0xA3, rlast on beat 4, first rvalid 2 cycles after the AR handshake.
- Backpressure: same read with rready toggling 1010... and held low for 5 cycles -> no lost or duplicated beats; rdata stable during the stall.
- Partial strobe: write 0xFF..FF, then write 0x0 with wstrb=64'hFF -> readback shows bytes 0-7 = 0 and the rest 0xFF.
- Wrap/range: AW addr 0xFFC0 len 1.
  - Macro off: the second beat lands at index 0.
  - Macro on: bresp=2'b10 and index 0 is unchanged.
- Length mismatch: awlen 1 with 3 beats, wlast on the 3rd -> bresp=2'b10 and the 3rd beat is not written.
- Reset mid-burst: pulse pipe_rst_n low after 2 of 4 W beats -> no bvalid; awready=1 on the first clk after release; a fresh burst completes normally.
